// File: rtl/str_match_pkg.sv
// Shared types and constants for the str_match streaming pattern matcher.
package str_match_pkg;

  localparam int unsigned PAT_MAX_DEF      = 8;
  localparam int unsigned STREAM_BYTES_DEF = 2048;
  localparam int unsigned CNT_W            = 12;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_LOAD  = 2'b10;
  localparam logic [1:0] CMD_ABORT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEARCH = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // ASCII upper-case letters fold onto lower case
  function automatic logic [7:0] fold_byte(input logic [7:0] b);
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/sm_window_cmp.sv
// Combinational compare of the byte window against the loaded pattern.
// STR_MATCH_CASE_FOLD_EN folds A-Z onto a-z on both sides before comparing.
module sm_window_cmp
  import str_match_pkg::*;
#(
  parameter int unsigned PAT_MAX = PAT_MAX_DEF
) (
  input  logic [PAT_MAX*8-1:0]          i_window,
  input  logic [PAT_MAX*8-1:0]          i_pat,
  input  logic [$clog2(PAT_MAX+1)-1:0]  i_pat_len,
  input  logic [$clog2(PAT_MAX+1)-1:0]  i_fill,
  output logic                          o_match_c
);

  logic [7:0] w_win [PAT_MAX];
  logic [7:0] w_pat [PAT_MAX];
  logic       w_eq;

  always_comb begin
    for (int i = 0; i < int'(PAT_MAX); i++) begin
`ifdef STR_MATCH_CASE_FOLD_EN
      w_win[i] = fold_byte(i_window[i*8 +: 8]);
      w_pat[i] = fold_byte(i_pat[i*8 +: 8]);
`else
      w_win[i] = i_window[i*8 +: 8];
      w_pat[i] = i_pat[i*8 +: 8];
`endif
    end
  end

  // window[len-1-i] must equal pat[i]; constant indices keep the mux shallow
  always_comb begin
    w_eq = 1'b1;
    for (int i = 0; i < int'(PAT_MAX); i++) begin
      for (int j = 0; j < int'(PAT_MAX); j++) begin
        if ((i + j + 1 == int'(i_pat_len)) && (w_win[j] != w_pat[i])) w_eq = 1'b0;
      end
    end
  end

  assign o_match_c = (i_pat_len != '0) && (i_fill >= i_pat_len) && w_eq;

endmodule

// File: rtl/str_match.sv
// Streaming byte-pattern matcher: load a pattern, then scan one fixed-length pass.
// Optional case folding via STR_MATCH_CASE_FOLD_EN (see sm_window_cmp).
module str_match
  import str_match_pkg::*;
#(
  parameter int unsigned PAT_MAX      = PAT_MAX_DEF,
  parameter int unsigned STREAM_BYTES = STREAM_BYTES_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        data_in,
  input  logic                              data_in_val,
  input  logic [1:0]                        command,
  input  logic [7:0]                        pat_in,
  input  logic                              pat_val,
  output logic                              match_pulse,
  output logic [$clog2(STREAM_BYTES)-1:0]   match_pos,
  output logic [CNT_W-1:0]                  match_cnt,
  output logic [$clog2(PAT_MAX+1)-1:0]      pat_len,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned LEN_W = $clog2(PAT_MAX + 1);
  localparam int unsigned POS_W = $clog2(STREAM_BYTES);
  localparam int unsigned WIN_W = PAT_MAX * 8;

  state_e                 r_state, w_state_nxt;
  logic [1:0]             r_cmd_d;
  logic [WIN_W-1:0]       r_pat;
  logic [WIN_W-9:0]       r_win;
  logic [WIN_W-1:0]       w_win_nxt;
  logic [LEN_W-1:0]       r_pat_len, r_fill, w_fill_nxt;
  logic [POS_W-1:0]       r_byte_idx, r_match_pos;
  logic [CNT_W-1:0]       r_match_cnt;
  logic                   r_match_pulse, r_done, r_busy;
  logic                   w_cmd_edge, w_start, w_load, w_abort;
  logic                   w_match, w_last;
  logic                   w_load_clr, w_pat_wr, w_search_clr, w_accept, w_win_clr;

  assign w_cmd_edge = (command != r_cmd_d);
  assign w_start    = w_cmd_edge && (command == CMD_START);
  assign w_load     = w_cmd_edge && (command == CMD_LOAD);
  assign w_abort    = w_cmd_edge && (command == CMD_ABORT);

  // History holds PAT_MAX-1 older bytes; the live byte completes the window
  assign w_win_nxt  = {r_win, data_in};
  assign w_fill_nxt = (r_fill == LEN_W'(PAT_MAX)) ? r_fill : r_fill + LEN_W'(1);
  assign w_last     = (r_byte_idx == POS_W'(STREAM_BYTES - 1));

  sm_window_cmp #(.PAT_MAX(PAT_MAX)) u_cmp (
    .i_window  (w_win_nxt),
    .i_pat     (r_pat),
    .i_pat_len (r_pat_len),
    .i_fill    (w_fill_nxt),
    .o_match_c (w_match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_load) w_state_nxt = ST_LOAD;
                   else if (w_start) w_state_nxt = ST_SEARCH;
        ST_LOAD:   if (command != CMD_LOAD) w_state_nxt = ST_IDLE;
        ST_SEARCH: if (data_in_val && w_last) w_state_nxt = ST_DONE;
        ST_DONE:   w_state_nxt = w_start ? ST_SEARCH : ST_IDLE;
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Datapath strobes; an abort edge overrides any other action that cycle
  always_comb begin
    w_load_clr   = 1'b0;
    w_pat_wr     = 1'b0;
    w_search_clr = 1'b0;
    w_accept     = 1'b0;
    w_win_clr    = w_abort;
    case (r_state)
      ST_IDLE: begin
        w_load_clr   = w_load;
        w_search_clr = w_start;
      end
      ST_LOAD:   w_pat_wr = (command == CMD_LOAD) && pat_val && (r_pat_len != LEN_W'(PAT_MAX));
      ST_SEARCH: w_accept = data_in_val && !w_abort;
      ST_DONE:   w_search_clr = w_start;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_d       <= '0;
      r_pat         <= '0;
      r_pat_len     <= '0;
      r_win         <= '0;
      r_fill        <= '0;
      r_byte_idx    <= '0;
      r_match_pos   <= '0;
      r_match_cnt   <= '0;
      r_match_pulse <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_cmd_d       <= command;
      r_match_pulse <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= (w_state_nxt == ST_SEARCH);
      if (w_load_clr) begin
        r_pat     <= '0;
        r_pat_len <= '0;
      end else if (w_pat_wr) begin
        for (int unsigned i = 0; i < PAT_MAX; i++) begin
          if (r_pat_len == LEN_W'(i)) r_pat[i*8 +: 8] <= pat_in;
        end
        r_pat_len <= r_pat_len + LEN_W'(1);
      end
      if (w_search_clr) begin
        r_win       <= '0;
        r_fill      <= '0;
        r_byte_idx  <= '0;
        r_match_pos <= '0;
        r_match_cnt <= '0;
      end else if (w_win_clr) begin
        r_win  <= '0;
        r_fill <= '0;
      end else if (w_accept) begin
        r_win      <= w_win_nxt[WIN_W-9:0];
        r_fill     <= w_fill_nxt;
        r_byte_idx <= r_byte_idx + POS_W'(1);
        r_done     <= w_last;
        if (w_match) begin
          r_match_pulse <= 1'b1;
          r_match_pos   <= r_byte_idx - POS_W'(r_pat_len) + POS_W'(1);
          if (r_match_cnt != {CNT_W{1'b1}}) r_match_cnt <= r_match_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign match_pulse = r_match_pulse;
  assign match_pos   = r_match_pos;
  assign match_cnt   = r_match_cnt;
  assign pat_len     = r_pat_len;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_str_match.sv
// Bench for str_match: transaction-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_str_match;

  localparam int PM = 8;
  localparam int SB = 2048;
`ifdef STR_MATCH_CASE_FOLD_EN
  localparam int FOLD = 1;
`else
  localparam int FOLD = 0;
`endif

  logic        clk, rst_n;
  logic [7:0]  data_in, pat_in;
  logic        data_in_val, pat_val;
  logic [1:0]  command;
  logic        match_pulse, busy, done;
  logic [10:0] match_pos;
  logic [11:0] match_cnt;
  logic [3:0]  pat_len;

  str_match dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_val(data_in_val),
    .command(command), .pat_in(pat_in), .pat_val(pat_val),
    .match_pulse(match_pulse), .match_pos(match_pos), .match_cnt(match_cnt),
    .pat_len(pat_len), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: abstract mode plus byte history since the pass started
  typedef enum {M_IDLE, M_LOAD, M_SEARCH, M_DONE} mmode_e;
  mmode_e     m_mode = M_IDLE;
  logic [7:0] m_pat[$];
  logic [7:0] m_hist[$];
  logic [1:0] m_cmd_prev = 2'b00;
  int m_seen = 0, m_pos = 0, m_cnt = 0;
  bit m_pulse = 0, m_done = 0;
  int exp_pulse = 0, exp_pos = 0, exp_cnt = 0, exp_len = 0, exp_busy = 0, exp_done = 0;

  function automatic logic [7:0] tb_fold(input logic [7:0] b);
`ifdef STR_MATCH_CASE_FOLD_EN
    if (b >= 8'h41 && b <= 8'h5A) return b + 8'h20;
`endif
    return b;
  endfunction

  function automatic bit model_hit();
    int l = m_pat.size();
    int n = m_hist.size();
    if (l == 0 || n < l) return 0;
    for (int i = 0; i < l; i++)
      if (tb_fold(m_hist[n-l+i]) != tb_fold(m_pat[i])) return 0;
    return 1;
  endfunction

  task automatic begin_pass();
    m_mode = M_SEARCH; m_seen = 0; m_cnt = 0; m_pos = 0; m_hist.delete();
  endtask

  task automatic model_cycle(input logic [1:0] c, input logic dv, input logic [7:0] d,
                             input logic pv, input logic [7:0] p);
    bit ed = (c != m_cmd_prev);
    m_cmd_prev = c;
    m_pulse = 0; m_done = 0;
    if (ed && c == 2'b11) begin
      m_mode = M_IDLE; m_hist.delete();
    end else begin
      case (m_mode)
        M_IDLE: if (ed && c == 2'b10) begin m_mode = M_LOAD; m_pat.delete(); end
                else if (ed && c == 2'b01) begin_pass();
        M_LOAD: if (c != 2'b10) m_mode = M_IDLE;
                else if (pv && m_pat.size() < PM) m_pat.push_back(p);
        M_SEARCH: if (dv) begin
          m_hist.push_back(d);
          if (m_hist.size() > PM) void'(m_hist.pop_front());
          m_seen++;
          if (model_hit()) begin
            m_pulse = 1; m_pos = m_seen - m_pat.size();
            if (m_cnt < 4095) m_cnt++;
          end
          if (m_seen == SB) begin m_done = 1; m_mode = M_DONE; end
        end
        M_DONE: if (ed && c == 2'b01) begin_pass(); else m_mode = M_IDLE;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [1:0] c, input logic dv, input logic [7:0] d,
                      input logic pv, input logic [7:0] p);
    command = c; data_in_val = dv; data_in = d; pat_val = pv; pat_in = p;
    model_cycle(c, dv, d, pv, p);
    @(posedge clk); #1;
    exp_pulse = int'(m_pulse); exp_done = int'(m_done); exp_pos = m_pos;
    exp_cnt = m_cnt; exp_len = m_pat.size(); exp_busy = (m_mode == M_SEARCH) ? 1 : 0;
  endtask

  // Per-cycle compare and event monitor, on the falling edge
  int mon_pos[$];
  int mon_at[$];
  int mon_done = 0, mon_both = 0, fed = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_pulse", int'(match_pulse), exp_pulse);
      chk("cyc_pos",   int'(match_pos),   exp_pos);
      chk("cyc_cnt",   int'(match_cnt),   exp_cnt);
      chk("cyc_len",   int'(pat_len),     exp_len);
      chk("cyc_busy",  int'(busy),        exp_busy);
      chk("cyc_done",  int'(done),        exp_done);
      if (match_pulse) begin mon_pos.push_back(int'(match_pos)); mon_at.push_back(fed); end
      if (done) mon_done++;
      if (done && match_pulse) mon_both++;
    end
  end

  logic [7:0] stream [SB];
  logic [7:0] pat_q[$];

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_stream();
    for (int i = 0; i < SB; i++) stream[i] = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  // First cycle is still IDLE, so its pat_val must be ignored
  task automatic load_pat();
    step(2'b10, 1'b1, 8'hEE, 1'b1, 8'hDD);
    foreach (pat_q[i]) step(2'b10, 1'b1, 8'hEE, 1'b1, pat_q[i]);
    step(2'b00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic start_pass();
    step(2'b00, 1'b0, 8'h00, 1'b0, 8'h00);
    step(2'b01, 1'b0, 8'h00, 1'b0, 8'h00);
    fed = 0;
  endtask

  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      if (k % 13 == 5) step(2'b01, 1'b0, 8'h61, 1'b1, 8'h55);
      step(2'b01, 1'b1, stream[k], 1'b0, 8'h00);
      fed++;
    end
  endtask

  task automatic abort_pass();
    step(2'b11, 1'b1, 8'h61, 1'b0, 8'h00);
    step(2'b00, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic hard_reset(input string pfx);
    chk_en = 0;
    rst_n = 1'b0;
    command = 2'b00; data_in_val = 1'b0; data_in = 8'h00; pat_val = 1'b0; pat_in = 8'h00;
    #1;
    chk({pfx, "_pulse"}, int'(match_pulse), 0);
    chk({pfx, "_pos"},   int'(match_pos),   0);
    chk({pfx, "_cnt"},   int'(match_cnt),   0);
    chk({pfx, "_len"},   int'(pat_len),     0);
    chk({pfx, "_busy"},  int'(busy),        0);
    chk({pfx, "_done"},  int'(done),        0);
    m_mode = M_IDLE; m_pat.delete(); m_hist.delete(); m_cmd_prev = 2'b00;
    m_seen = 0; m_pos = 0; m_cnt = 0; m_pulse = 0; m_done = 0;
    exp_pulse = 0; exp_pos = 0; exp_cnt = 0; exp_len = 0; exp_busy = 0; exp_done = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int d0;

  initial begin
    rst_n = 1'b0;
    hard_reset("por");

    // Single match at offset 1
    clear_stream();
    stream[0] = 8'h78; stream[1] = 8'h61; stream[2] = 8'h62; stream[3] = 8'h79;
    pat_q = {8'h61, 8'h62}; load_pat();
    chk("s1_patlen", int'(pat_len), 2);
    mon_pos.delete(); mon_at.delete(); d0 = mon_done;
    start_pass(); feed(SB); idle(2);
    chk("s1_npulse", mon_pos.size(), 1);
    chk("s1_pos", qget(mon_pos, 0), 1);
    chk("s1_at", qget(mon_at, 0), 3);
    chk("s1_cnt", int'(match_cnt), 1);
    chk("s1_model_cnt", m_cnt, 1);
    chk("s1_done", mon_done - d0, 1);

    // Overlapping matches
    clear_stream();
    for (int i = 0; i < 4; i++) stream[i] = 8'h61;
    pat_q = {8'h61, 8'h61}; load_pat();
    mon_pos.delete(); d0 = mon_done;
    start_pass(); feed(SB); idle(2);
    chk("s2_npulse", mon_pos.size(), 3);
    chk("s2_pos0", qget(mon_pos, 0), 0);
    chk("s2_pos1", qget(mon_pos, 1), 1);
    chk("s2_pos2", qget(mon_pos, 2), 2);
    chk("s2_cnt", int'(match_cnt), 3);
    chk("s2_done", mon_done - d0, 1);

    // Match on the last two bytes of the pass
    clear_stream();
    stream[2046] = 8'h61; stream[2047] = 8'h62;
    pat_q = {8'h61, 8'h62}; load_pat();
    mon_pos.delete(); d0 = mon_done; mon_both = 0;
    start_pass(); feed(SB); idle(2);
    chk("s3_pos", qget(mon_pos, 0), 2046);
    chk("s3_both", mon_both, 1);
    chk("s3_cnt", int'(match_cnt), 1);
    chk("s3_done", mon_done - d0, 1);

    // Pattern overflow and case folding
    pat_q = {8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49}; load_pat();
    chk("s4_patlen_sat", int'(pat_len), 8);
    chk("s4_model_len", m_pat.size(), 8);
    pat_q = {8'h41, 8'h42}; load_pat();
    clear_stream(); stream[0] = 8'h61; stream[1] = 8'h62;
    start_pass(); feed(2);
    chk("s4_fold_cnt", int'(match_cnt), FOLD);
    abort_pass();

    // Abort after 50 bytes keeps count and pattern
    pat_q = {8'h61, 8'h62}; load_pat();
    clear_stream();
    stream[10] = 8'h61; stream[11] = 8'h62; stream[30] = 8'h61; stream[31] = 8'h62;
    d0 = mon_done;
    start_pass(); feed(50); abort_pass();
    chk("s6_busy", int'(busy), 0);
    chk("s6_cnt", int'(match_cnt), 2);
    chk("s6_patlen", int'(pat_len), 2);
    chk("s6_nodone", mon_done - d0, 0);
    clear_stream(); stream[0] = 8'h61; stream[1] = 8'h62;
    mon_pos.delete();
    start_pass(); feed(4);
    chk("s6_restart_cnt", int'(match_cnt), 1);
    chk("s6_restart_pos", qget(mon_pos, 0), 0);
    abort_pass();

    // Reset mid-search, then a full pass
    pat_q = {8'h61, 8'h62}; load_pat();
    clear_stream(); stream[50] = 8'h61; stream[51] = 8'h62;
    d0 = mon_done;
    start_pass(); feed(100);
    chk("s5_cnt_pre", int'(match_cnt), 1);
    hard_reset("s5_rst");
    idle(3);
    chk("s5_nodone", mon_done - d0, 0);
    load_pat();
    start_pass(); feed(SB); idle(2);
    chk("s5_cnt", int'(match_cnt), 1);
    chk("s5_done", mon_done - d0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/str_match.md
STR_MATCH -- requirements
Module: str_match

Interface
REQ-001 SHALL have parameter PAT_MAX, default 8, giving the maximum pattern length in bytes.
REQ-002 SHALL have parameter STREAM_BYTES, default 2048, giving the bytes per search pass (512 words x 4).
REQ-003 SHALL have port clk  input  1  as the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  as the reset, which is asynchronous and active-low.
REQ-005 SHALL have port data_in  input  8  as the byte stream from the upstream byte serializer.
REQ-006 SHALL have port data_in_val  input  1  to qualify data_in for one byte per cycle.
REQ-007 SHALL have port command  input  2  with codes 01 start, 10 load pattern and 11 abort.
REQ-008 SHALL have port pat_in  input  8  as a pattern byte.
REQ-009 SHALL have port pat_val  input  1  to qualify pat_in.
REQ-010 SHALL have port match_pulse  output  1  as a one-cycle match strobe.
REQ-011 SHALL have port match_pos  output  11  as the stream offset of the first byte of the latest match.
REQ-012 SHALL have port match_cnt  output  12  as the number of matches in the current or last pass.
REQ-013 SHALL have port pat_len  output  4  as the number of pattern bytes loaded.
REQ-014 SHALL have port busy  output  1  asserted high while in SEARCH.
REQ-015 SHALL have port done  output  1  as a one-cycle end-of-pass strobe.

Function
REQ-016 SHALL implement states IDLE, LOAD, SEARCH and DONE, registered with the state register in a separate block.
REQ-017 SHALL sample command into cmd_d each cycle and SHALL treat "command != cmd_d" as a command edge.
REQ-018 SHALL go from IDLE to LOAD on a 10 edge, and on entry to LOAD SHALL clear the pattern and set pat_len=0.
REQ-019 SHALL, in LOAD with pat_val=1, store pat_in at index pat_len and increment pat_len; once pat_len==PAT_MAX it SHALL ignore further bytes and hold pat_len at PAT_MAX.
REQ-020 SHALL return from LOAD to IDLE when command != 10.
REQ-021 SHALL go from IDLE or DONE to SEARCH on a 01 edge, clearing byte_idx, match_cnt, match_pos and the window fill count.
REQ-022 SHALL, in SEARCH with data_in_val=1, shift data_in into a PAT_MAX-byte window (newest at [0]), increment byte_idx, and increment the fill count with saturation at PAT_MAX.
REQ-023 SHALL declare a match when pat_len>0, fill (including the current byte) >= pat_len, and window[pat_len-1-i]==pat[i] for all i<pat_len.
REQ-024 SHALL count overlapping matches individually.
REQ-025 SHALL, on a match, assert match_pulse exactly one cycle after the accepting cycle, with match_pos=byte_idx_of_current_byte-pat_len+1 and match_cnt incremented by 1.
REQ-026 SHALL saturate match_cnt at 4095.
REQ-027 SHALL, after accepting byte number STREAM_BYTES-1, go to DONE and assert done in the same cycle as any match_pulse for that byte.
REQ-028 SHALL go from DONE to IDLE on the next cycle unless a 01 edge occurs.
REQ-029 SHALL, on an 11 edge in any state, go to IDLE, clear the window and fill count, keep match_cnt and the pattern, and raise no done.
REQ-030 SHALL ignore data_in_val outside SEARCH.
REQ-031 SHALL ignore pat_val outside LOAD.
REQ-032 SHALL, in SEARCH with pat_len==0, consume the stream, report no matches, and still assert done.

Reset
REQ-033 SHALL, while rst_n=0, immediately force state=IDLE and all outputs to 0 (match_pulse, match_pos, match_cnt, pat_len, busy, done), and clear the pattern, window, byte_idx and cmd_d.
REQ-034 SHALL, on reset asserted mid-SEARCH, abandon the pass and report no done.

Configuration
REQ-035 SHALL, with STR_MATCH_CASE_FOLD_EN defined, map bytes 0x41-0x5A to +0x20 in both pattern and data before comparison.
REQ-036 SHALL, without STR_MATCH_CASE_FOLD_EN, compare bytes exactly.

Structure
REQ-037 SHALL place in a shared package str_match_pkg: the state enum, the command codes CMD_START/CMD_LOAD/CMD_ABORT, PAT_MAX_DEF and STREAM_BYTES_DEF.
REQ-038 SHALL implement the window/pattern compare, including the case fold, as sub-module sm_window_cmp (combinational, PAT_MAX-wide).

Verification
REQ-039 SHALL verify: load pattern 61 62, start, stream with 78 61 62 79 at offsets 0-3 and the rest 00 -> one match_pulse at cycle after offset 2, match_pos=1, final match_cnt=1, one done.
REQ-040 SHALL verify: pattern 61 61, stream 61 61 61 61 then 00 -> match_pos sequence 0,1,2, match_cnt=3.
REQ-041 SHALL verify: pattern 61 62 at offsets 2046-2047 -> match_pulse and done in the same cycle, match_pos=2046.
REQ-042 SHALL verify: load 9 bytes 41 42 43 44 45 46 47 48 49 -> pat_len=8; pattern 41 42 with stream 61 62 -> match with STR_MATCH_CASE_FOLD_EN defined, none without.
REQ-043 SHALL verify: rst_n low after 100 bytes of SEARCH -> all outputs 0 at once, no done; restart then yields a full pass.
REQ-044 SHALL verify: abort (11) after 50 bytes -> busy=0, match_cnt held, no done, pattern kept for the next start.
